// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional macro ID_EX_STALL_COUNT_EN adds saturating StallCount/FlushCount outputs.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Flush,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              Jump,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Opcode,
    input  logic [5:0]        Funct,
    input  logic [DATA_W-1:0] PC4,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] SignExtImm,
    input  logic [REG_W-1:0]  Rs,
    input  logic [REG_W-1:0]  Rt,
    input  logic [REG_W-1:0]  Rd,
    output logic              Stall,
    output logic              EX_RegDst,
    output logic              EX_ALUSrc,
    output logic              EX_MemtoReg,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_Branch,
    output logic              EX_Jump,
    output logic [1:0]        EX_ALUOp,
    output logic [5:0]        EX_Opcode,
    output logic [5:0]        EX_Funct,
    output logic [DATA_W-1:0] EX_PC4,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_SignExtImm,
    output logic [REG_W-1:0]  EX_Rs,
    output logic [REG_W-1:0]  EX_Rt,
    output logic [REG_W-1:0]  EX_Rd,
`ifdef ID_EX_STALL_COUNT_EN
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount,
`endif
    output logic              EX_Valid
);

    // Control bundle order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump ALUOp[1:0]
    logic [9:0]        ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [5:0]        opcode_q, funct_q;
    logic [DATA_W-1:0] pc4_q, rd1_q, rd2_q, imm_q;
    logic [REG_W-1:0]  rs_q, rt_q, rd_q;
    logic              hazard;

    assign hazard = ctrl_q[5] & valid_q & (rt_q != '0) & ((rt_q == Rs) | (rt_q == Rt));
    assign Stall  = hazard & ~Flush;

    // Only control and valid are squashed; datapath fields always load.
    always_comb begin
        ctrl_d  = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp};
        valid_d = 1'b1;
        if (Flush || hazard) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            funct_q  <= '0;
            pc4_q    <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            opcode_q <= Opcode;
            funct_q  <= Funct;
            pc4_q    <= PC4;
            rd1_q    <= ReadData1;
            rd2_q    <= ReadData2;
            imm_q    <= SignExtImm;
            rs_q     <= Rs;
            rt_q     <= Rt;
            rd_q     <= Rd;
        end
    end

    assign {EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite,
            EX_MemRead, EX_MemWrite, EX_Branch, EX_Jump, EX_ALUOp} = ctrl_q;
    assign EX_Valid      = valid_q;
    assign EX_Opcode     = opcode_q;
    assign EX_Funct      = funct_q;
    assign EX_PC4        = pc4_q;
    assign EX_ReadData1  = rd1_q;
    assign EX_ReadData2  = rd2_q;
    assign EX_SignExtImm = imm_q;
    assign EX_Rs         = rs_q;
    assign EX_Rt         = rt_q;
    assign EX_Rd         = rd_q;

`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (Flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, load-use stall, flush priority, back-to-back loads.
// Counter checks are included when ID_EX_STALL_COUNT_EN is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Flush;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
    logic [1:0]  ALUOp;
    logic [5:0]  Opcode, Funct;
    logic [31:0] PC4, ReadData1, ReadData2, SignExtImm;
    logic [4:0]  Rs, Rt, Rd;
    logic        Stall;
    logic        EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch, EX_Jump;
    logic [1:0]  EX_ALUOp;
    logic [5:0]  EX_Opcode, EX_Funct;
    logic [31:0] EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignExtImm;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
    logic        EX_Valid;
`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] StallCount, FlushCount;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .ALUOp(ALUOp), .Opcode(Opcode), .Funct(Funct), .PC4(PC4),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExtImm(SignExtImm),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Stall(Stall),
        .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc), .EX_MemtoReg(EX_MemtoReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_Branch(EX_Branch), .EX_Jump(EX_Jump), .EX_ALUOp(EX_ALUOp),
        .EX_Opcode(EX_Opcode), .EX_Funct(EX_Funct), .EX_PC4(EX_PC4),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_SignExtImm(EX_SignExtImm),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
`ifdef ID_EX_STALL_COUNT_EN
        .StallCount(StallCount), .FlushCount(FlushCount),
`endif
        .EX_Valid(EX_Valid)
    );

    // Packed view of registered control: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump ALUOp
    logic [9:0] ex_ctrl;
    assign ex_ctrl = {EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead,
                      EX_MemWrite, EX_Branch, EX_Jump, EX_ALUOp};

    // Clock edge then settle; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] ctrl, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = ctrl;
        Opcode = op; Funct = fn; Rs = rs; Rt = rt; Rd = rd;
        PC4 = 32'h0000_1000 + {27'd0, rd}; ReadData1 = 32'hA000_0000 + {27'd0, rs};
        ReadData2 = 32'hB000_0000 + {27'd0, rt}; SignExtImm = 32'hFFFF_FFF0 + {27'd0, rd};
        #1;
    endtask

    // ctrl constants: ADD = RegDst|RegWrite|ALUOp=10, LW = ALUSrc|MemtoReg|RegWrite|MemRead, SW = ALUSrc|MemWrite
    task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        drive(10'b1001_0000_10, 6'h00, 6'h20, rs, rt, rd);
    endtask
    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
        drive(10'b0111_1000_00, 6'h23, 6'h00, rs, rt, 5'd0);
    endtask
    task automatic drive_sw(input logic [4:0] rs, input logic [4:0] rt);
        drive(10'b0100_0100_00, 6'h2b, 6'h00, rs, rt, 5'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1; Flush = 1'b0;
        drive_add(5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (ex_ctrl !== 10'd0 || EX_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl cyc%0d: ctrl=%b valid=%b required ctrl=0 valid=0", i, ex_ctrl, EX_Valid); end
            n_cmp++; if ({EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignExtImm} !== 128'd0 || {EX_Opcode, EX_Funct, EX_Rs, EX_Rt, EX_Rd} !== 27'd0) begin n_fail++; $display("FAIL reset_data cyc%0d: pc4=%h rs=%0d rd=%0d required all 0", i, EX_PC4, EX_Rs, EX_Rd); end
            n_cmp++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", Stall); end
        end
        reset = 1'b0;
        step();
        n_cmp++; if (ex_ctrl !== 10'b1001_0000_10 || EX_Valid !== 1'b1) begin n_fail++; $display("FAIL add_first ctrl=%b valid=%b required 1001000010 valid=1", ex_ctrl, EX_Valid); end
        n_cmp++; if (EX_Rd !== 5'd3 || EX_Rs !== 5'd1 || EX_Rt !== 5'd2 || EX_Funct !== 6'h20) begin n_fail++; $display("FAIL add_regs rs=%0d rt=%0d rd=%0d funct=%h required 1 2 3 20", EX_Rs, EX_Rt, EX_Rd, EX_Funct); end
        n_cmp++; if (EX_PC4 !== 32'h0000_1003 || EX_ReadData1 !== 32'hA000_0001 || EX_ReadData2 !== 32'hB000_0002 || EX_SignExtImm !== 32'hFFFF_FFF3) begin n_fail++; $display("FAIL add_data pc4=%h r1=%h r2=%h imm=%h required 00001003 a0000001 b0000002 fffffff3", EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignExtImm); end
    endtask

    task automatic test_load_use();
        drive_lw(5'd1, 5'd8);
        step();
        n_cmp++; if (EX_MemRead !== 1'b1 || EX_Rt !== 5'd8 || EX_Valid !== 1'b1 || EX_Opcode !== 6'h23) begin n_fail++; $display("FAIL lw_in_ex memread=%b rt=%0d valid=%b op=%h required 1 8 1 23", EX_MemRead, EX_Rt, EX_Valid, EX_Opcode); end
        drive_add(5'd8, 5'd2, 5'd10);
        n_cmp++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b required 1", Stall); end
        step();
        n_cmp++; if (ex_ctrl !== 10'd0 || EX_Valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble ctrl=%b valid=%b required 0 0", ex_ctrl, EX_Valid); end
        n_cmp++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release got %b required 0", Stall); end
        step();
        n_cmp++; if (EX_Valid !== 1'b1 || EX_RegWrite !== 1'b1 || EX_Rd !== 5'd10 || EX_Rs !== 5'd8) begin n_fail++; $display("FAIL lu_add_enters valid=%b regwrite=%b rd=%0d rs=%0d required 1 1 10 8", EX_Valid, EX_RegWrite, EX_Rd, EX_Rs); end
    endtask

    task automatic test_rt_zero();
        drive_lw(5'd1, 5'd0);
        step();
        drive_add(5'd0, 5'd0, 5'd4);
        n_cmp++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL rt0_stall got %b required 0", Stall); end
        step();
        n_cmp++; if (EX_Valid !== 1'b1 || EX_Rd !== 5'd4 || EX_RegDst !== 1'b1) begin n_fail++; $display("FAIL rt0_no_bubble valid=%b rd=%0d regdst=%b required 1 4 1", EX_Valid, EX_Rd, EX_RegDst); end
    endtask

    task automatic test_flush_hazard();
        drive_lw(5'd1, 5'd9);
        step();
        drive_sw(5'd2, 5'd9);
        Flush = 1'b1; #1;
        n_cmp++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL flush_hz_stall got %b required 0", Stall); end
        step();
        Flush = 1'b0;
        n_cmp++; if (EX_MemWrite !== 1'b0 || EX_Valid !== 1'b0 || ex_ctrl !== 10'd0) begin n_fail++; $display("FAIL flush_hz_bubble memwrite=%b valid=%b ctrl=%b required 0 0 0", EX_MemWrite, EX_Valid, ex_ctrl); end
        // Plain flush with no hazard pending.
        drive_add(5'd3, 5'd4, 5'd5);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        n_cmp++; if (ex_ctrl !== 10'd0 || EX_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_plain ctrl=%b valid=%b required 0 0", ex_ctrl, EX_Valid); end
    endtask

    task automatic test_sw_no_hazard();
        drive_sw(5'd1, 5'd5);
        step();
        drive_add(5'd5, 5'd3, 5'd7);
        n_cmp++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall got %b required 0", Stall); end
        step();
        n_cmp++; if (EX_Valid !== 1'b1 || EX_Rd !== 5'd7 || ex_ctrl !== 10'b1001_0000_10) begin n_fail++; $display("FAIL sw_follow valid=%b rd=%0d ctrl=%b required 1 7 1001000010", EX_Valid, EX_Rd, ex_ctrl); end
    endtask

    task automatic test_back_to_back();
        drive_lw(5'd1, 5'd4);
        step();
        drive_lw(5'd4, 5'd6);
        n_cmp++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL b2b_dep_stall got %b required 1", Stall); end
        step();
        n_cmp++; if (EX_Valid !== 1'b0 || EX_MemRead !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble valid=%b memread=%b required 0 0", EX_Valid, EX_MemRead); end
        step();
        n_cmp++; if (EX_Valid !== 1'b1 || EX_MemRead !== 1'b1 || EX_Rt !== 5'd6) begin n_fail++; $display("FAIL b2b_second_lw valid=%b memread=%b rt=%0d required 1 1 6", EX_Valid, EX_MemRead, EX_Rt); end
        drive_lw(5'd2, 5'd7);
        n_cmp++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL b2b_indep_stall got %b required 0", Stall); end
        step();
        n_cmp++; if (EX_Valid !== 1'b1 || EX_Rt !== 5'd7 || EX_Rs !== 5'd2) begin n_fail++; $display("FAIL b2b_indep_load valid=%b rt=%0d rs=%0d required 1 7 2", EX_Valid, EX_Rt, EX_Rs); end
    endtask

    task automatic test_reset_mid_stall();
        drive_lw(5'd1, 5'd8);
        step();
        drive_add(5'd2, 5'd8, 5'd11);
        n_cmp++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_stall got %b required 1", Stall); end
        reset = 1'b1;
        step();
        n_cmp++; if (ex_ctrl !== 10'd0 || EX_Valid !== 1'b0 || EX_Rt !== 5'd0 || Stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clear ctrl=%b valid=%b rt=%0d stall=%b required 0 0 0 0", ex_ctrl, EX_Valid, EX_Rt, Stall); end
        reset = 1'b0;
        step();
        n_cmp++; if (EX_Valid !== 1'b1 || EX_Rd !== 5'd11) begin n_fail++; $display("FAIL rst_mid_resume valid=%b rd=%0d required 1 11", EX_Valid, EX_Rd); end
    endtask

`ifdef ID_EX_STALL_COUNT_EN
    task automatic test_counters();
        reset = 1'b1; Flush = 1'b0;
        drive(10'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        step();
        reset = 1'b0;
        n_cmp++; if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin n_fail++; $display("FAIL cnt_init stall=%0d flush=%0d required 0 0", StallCount, FlushCount); end
        for (int i = 0; i < 3; i++) begin
            drive_lw(5'd1, 5'd12);
            step();
            drive_add(5'd12, 5'd1, 5'd13);
            step();
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive_add(5'd1, 5'd2, 5'd3);
            Flush = 1'b1;
            step();
            Flush = 1'b0;
        end
        n_cmp++; if (StallCount !== 32'd3 || FlushCount !== 32'd2) begin n_fail++; $display("FAIL cnt_values stall=%0d flush=%0d required 3 2", StallCount, FlushCount); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin n_fail++; $display("FAIL cnt_reset stall=%0d flush=%0d required 0 0", StallCount, FlushCount); end
    endtask
`endif

    initial begin
        reset = 1'b1; Flush = 1'b0;
        drive(10'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_load_use();
        test_rt_zero();
        test_flush_hazard();
        test_sw_no_hazard();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef ID_EX_STALL_COUNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the MIPS pipeline, with integrated load-use hazard detection.
- Captures the nine control signals produced by the instruction-decode control logic, plus operands, immediate and register specifiers. Presents them, registered, to the EX stage (ALU control, ALU, forwarding).
- Drives the stall request that freezes PC and IF/ID.
- Inserts bubbles on load-use hazards and on branch/jump flushes.

Parameters:
- DATA_W, 32, width of PC+4, operand and immediate datapaths
- REG_W, 5, width of register specifiers

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- Flush  input  1  branch taken / jump resolved: squash the instruction currently in ID
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump  input  1 each  decoded control from ID
- ALUOp  input  2  decoded ALU operation class from ID
- Opcode  input  6  instruction[31:26], forwarded for ALU control of immediate ops
- Funct  input  6  instruction[5:0]
- PC4  input  DATA_W  PC+4 of the ID instruction
- ReadData1, ReadData2  input  DATA_W  register file read values
- SignExtImm  input  DATA_W  sign-extended immediate
- Rs, Rt, Rd  input  REG_W  instruction register fields
- Stall  output  1  1 = hold PC and IF/ID this cycle (combinational)
- EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch, EX_Jump  output  1 each  registered control
- EX_ALUOp  output  2  registered
- EX_Opcode, EX_Funct  output  6 each  registered
- EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignExtImm  output  DATA_W  registered
- EX_Rs, EX_Rt, EX_Rd  output  REG_W  registered
- EX_Valid  output  1  1 = real instruction in EX, 0 = bubble

Behaviour:
- Reset: every EX_* output is 0, including EX_Valid. Stall is 0.
- Hazard detect (combinational, from registered state):
  - hazard = EX_MemRead & EX_Valid & (EX_Rt != 0) & ((EX_Rt == Rs) | (EX_Rt == Rt)).
  - Stall = hazard & ~Flush.
- Register update, priority per rising edge:
  1. reset: clear all.
  2. Flush: load a bubble.
  3. hazard: load a bubble.
  4. otherwise: load all inputs; EX_Valid = 1.
- Bubble definition:
  - RegWrite, MemRead, MemWrite, Branch, Jump, RegDst, ALUSrc, MemtoReg all 0; ALUOp = 00; EX_Valid = 0.
  - Datapath fields (PC4, operands, imm, Rs/Rt/Rd, Opcode, Funct) still load from inputs. They are don't-care, but keeping them avoids extra muxing.
- Latency: exactly 1 cycle from ID inputs to EX_* outputs.
- Load-use behaviour:
  - One bubble per load-use pair.
  - The cycle after the stall, EX holds the bubble (EX_MemRead = 0), so hazard deasserts and the held ID instruction loads normally.
- Flush during hazard: Flush wins. Stall = 0 and a bubble is loaded, so the squashed instruction never stalls the front end.
- Rs/Rt = 0 never triggers a hazard.
- Back-to-back loads:
  - The second load depends on the first: one stall.
  - Otherwise: no stall.
- Reset asserted mid-stall: outputs clear on that edge; Stall drops as soon as EX_* clear.

Optional Feature:
- Macro ID_EX_STALL_COUNT_EN.
- When defined, adds output StallCount [31:0] and output FlushCount [31:0]:
  - Each is cleared by reset.
  - StallCount increments on every edge where Stall = 1; FlushCount increments on every edge where Flush = 1.
  - Both saturate at 0xFFFFFFFF.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with ADD inputs (RegDst=1, RegWrite=1, ALUOp=10, Rd=3) -> all EX_* = 0 during reset; next edge EX_RegDst=1, EX_RegWrite=1, EX_ALUOp=10, EX_Rd=3, EX_Valid=1.
- LW $t0(Rt=8) loaded, then ADD with Rs=8 in ID -> Stall=1 for one cycle; next EX_* is a bubble (EX_RegWrite=0, EX_Valid=0); following edge ADD enters EX; Stall=0.
- LW Rt=0, then instruction with Rs=0 -> Stall=0, no bubble.
- LW Rt=9 in EX, ID Rt=9, Flush=1 same cycle -> Stall=0; bubble loaded; EX_MemWrite=0, EX_Valid=0.
- SW Rt=5 in EX (MemRead=0), ID Rs=5 -> Stall=0; ID instruction loads normally.
- With ID_EX_STALL_COUNT_EN: three load-use pairs and two flushes -> StallCount=3, FlushCount=2; reset -> both 0.
